// File: rtl/spi_rx_word.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_word
// Description : SPI receive engine. Deserialises sdi on rx_edge_i strobes into
//               DATA_W-bit words behind a one-word valid/ready output buffer.
//               Define SPI_RX_LSB_FIRST_EN to build the LSB-first write path.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_word #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              sdi,
    input  logic              rx_edge_i,
    input  logic              lsb_first_i,
    input  logic [LEN_W-1:0]  rx_bits_len_i,
    input  logic              rx_bits_len_update_i,
    output logic              rx_stall_o,
    output logic              rx_busy_o,
    output logic              rx_done_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic [CNT_W-1:0]  rx_data_bits_o,
    output logic              rx_last_o,
    output logic              rx_data_vld_o,
    input  logic              rx_data_rdy_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        STALL   = 2'd2
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  total_cnt;
    logic [LEN_W-1:0]  total_nxt;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  word_nxt;
    logic [CNT_W-1:0]  pend_bits;
    logic              pend_last;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nxt;
    logic              xfer_last;
    logic              word_done;
    logic              accept;
    logic              out_free;

    assign accept    = rx_data_vld_o && rx_data_rdy_i;
    assign out_free  = !rx_data_vld_o || accept;
    assign total_nxt = total_cnt + LEN_W'(1);
    assign word_nxt  = word_cnt + CNT_W'(1);
    assign xfer_last = (total_nxt == len_q);
    assign word_done = (word_nxt == CNT_W'(DATA_W)) || xfer_last;

    assign rx_stall_o = (state == STALL);
    assign rx_busy_o  = (state != IDLE) || rx_data_vld_o;

`ifdef SPI_RX_LSB_FIRST_EN
    logic lsb_q;

    // LSB-first writes each bit straight into its final position, so partial
    // words come out right-aligned without a final realignment step.
    always_comb begin
        shift_nxt = {shift_q[DATA_W-2:0], sdi};
        if (lsb_q) begin
            shift_nxt = shift_q;
            for (int i = 0; i < DATA_W; i++) begin
                if (word_cnt == CNT_W'(i)) begin
                    shift_nxt[i] = sdi;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lsb_q <= 1'b0;
        end else if (state == IDLE && en_i && len_q != '0) begin
            lsb_q <= lsb_first_i;
        end
    end
`else
    logic unused_lsb_first;
    assign unused_lsb_first = lsb_first_i;
    assign shift_nxt        = {shift_q[DATA_W-2:0], sdi};
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            len_q          <= '0;
            total_cnt      <= '0;
            word_cnt       <= '0;
            pend_bits      <= '0;
            pend_last      <= 1'b0;
            shift_q        <= '0;
            rx_done_o      <= 1'b0;
            rx_data_o      <= '0;
            rx_data_bits_o <= '0;
            rx_last_o      <= 1'b0;
            rx_data_vld_o  <= 1'b0;
        end else begin
            rx_done_o <= accept && rx_last_o;
            // Default drop of valid on acceptance; a same-cycle load below wins.
            if (accept) begin
                rx_data_vld_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (en_i && len_q != '0) begin
                        state     <= RECEIVE;
                        total_cnt <= '0;
                        word_cnt  <= '0;
                        shift_q   <= '0;
                    end else if (rx_bits_len_update_i) begin
                        len_q <= rx_bits_len_i;
                    end
                end

                RECEIVE: begin
                    if (rx_edge_i) begin
                        total_cnt <= total_nxt;
                        if (word_done) begin
                            word_cnt <= '0;
                            if (out_free) begin
                                rx_data_o      <= shift_nxt;
                                rx_data_bits_o <= word_nxt;
                                rx_last_o      <= xfer_last;
                                rx_data_vld_o  <= 1'b1;
                                shift_q        <= '0;
                                if (xfer_last) begin
                                    state <= IDLE;
                                end
                            end else begin
                                // Shift register becomes the second buffer.
                                shift_q   <= shift_nxt;
                                pend_bits <= word_nxt;
                                pend_last <= xfer_last;
                                state     <= STALL;
                            end
                        end else begin
                            word_cnt <= word_nxt;
                            shift_q  <= shift_nxt;
                        end
                    end
                end

                STALL: begin
                    if (accept) begin
                        rx_data_o      <= shift_q;
                        rx_data_bits_o <= pend_bits;
                        rx_last_o      <= pend_last;
                        rx_data_vld_o  <= 1'b1;
                        shift_q        <= '0;
                        state          <= pend_last ? IDLE : RECEIVE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_word.sv
`default_nettype none
// Self-checking bench for spi_rx_word: table of transfers, scoreboard of
// expected words, plus hand sequences for reset, zero length and stall.
`timescale 1ns/1ps
module tb_spi_rx_word;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int CNT_W  = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              sdi = 1'b0;
    logic              edge_s = 1'b0;
    logic              lsb = 1'b0;
    logic              len_upd = 1'b0;
    logic              rdy = 1'b1;
    logic [LEN_W-1:0]  len = '0;
    logic              stall, busy, done, last, vld;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  nbits;

    always #5 clk = ~clk;

    spi_rx_word #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .sdi(sdi), .rx_edge_i(edge_s),
        .lsb_first_i(lsb), .rx_bits_len_i(len), .rx_bits_len_update_i(len_upd),
        .rx_stall_o(stall), .rx_busy_o(busy), .rx_done_o(done), .rx_data_o(data),
        .rx_data_bits_o(nbits), .rx_last_o(last), .rx_data_vld_o(vld),
        .rx_data_rdy_i(rdy)
    );

    typedef struct {
        int           len;
        bit           lsb;
        logic [127:0] bits;      // bits[len-1] is sent first
        bit           hold_rdy;  // keep rdy low until the engine stalls
        bit           upd_mid;   // try a length update mid-transfer
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  nb;
        bit                last;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[8];
    int   checks = 0;
    int   failures = 0;
    bit   prev_acc = 0;
    bit   prev_last = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Word model: group sent bits into DATA_W chunks, last chunk partial.
    function automatic void push_expected(vec_t v);
        logic [DATA_W-1:0] w;
        int n;
        bit eff_lsb;
`ifdef SPI_RX_LSB_FIRST_EN
        eff_lsb = v.lsb;
`else
        eff_lsb = 1'b0;
`endif
        w = '0;
        n = 0;
        for (int k = 0; k < v.len; k++) begin
            logic b;
            exp_t e;
            b = v.bits[v.len-1-k];
            if (eff_lsb) w[n] = b;
            else w = {w[DATA_W-2:0], b};
            n++;
            if (n == DATA_W || k == v.len - 1) begin
                e.data = w;
                e.nb   = CNT_W'(n);
                e.last = (k == v.len - 1);
                sbq.push_back(e);
                w = '0;
                n = 0;
            end
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (prev_acc) check("done", done, prev_last);
            prev_acc  = vld && rdy;
            prev_last = last;
            if (vld && rdy) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %0h required none", data);
                end else begin
                    e = sbq.pop_front();
                    check("data", data, e.data);
                    check("bits", nbits, e.nb);
                    check("last", last, e.last);
                end
            end
        end else begin
            prev_acc = 0;
        end
    end

    task automatic run(vec_t v, int idx);
        int k = 0;
        int junk = 0;
        int guard = 0;
        bit stall_seen = 0;
        push_expected(v);
        rdy = !v.hold_rdy;
        @(posedge clk); #1;
        len = LEN_W'(v.len); len_upd = 1'b1; lsb = v.lsb;
        @(posedge clk); #1;
        len_upd = 1'b0; en = 1'b1; edge_s = 1'b1; sdi = 1'b1;  // strobe on start cycle must be ignored
        @(posedge clk); #1;
        en = 1'b0;
        while (k < v.len && guard < 4000) begin
            guard++;
            edge_s  = 1'b1;
            len_upd = 1'b0;
            if (stall) begin
                stall_seen = 1;
                sdi = 1'b1;
                junk++;
                if (junk == 4) rdy = 1'b1;
            end else begin
                sdi = v.bits[v.len-1-k];
                k++;
                if (v.upd_mid && k == 3) begin
                    len = 16; len_upd = 1'b1;
                end
            end
            if (idx == 0 && k == v.len) begin
                @(negedge clk);
                check("vld_before_latency", vld, 0);
            end
            @(posedge clk); #1;
        end
        edge_s = 1'b0; len_upd = 1'b0;
        if (idx == 0) begin
            @(negedge clk);
            check("vld_latency", vld, 1);
        end
        guard = 0;
        while ((sbq.size() != 0 || busy) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check("drained", sbq.size(), 0);
        check("stall_seen", stall_seen, v.hold_rdy);
        check("idle_busy", busy, 0);
        sbq.delete();
    endtask

    initial begin
        tbl[0] = '{32, 1'b0, 128'hA5A50F0F, 1'b0, 1'b0};
        tbl[1] = '{40, 1'b0, {88'h0, 32'h12345678, 8'h9A}, 1'b0, 1'b0};
        tbl[2] = '{8, 1'b1, 128'h81, 1'b0, 1'b0};
        tbl[3] = '{8, 1'b1, 128'hC0, 1'b0, 1'b0};
        tbl[4] = '{96, 1'b0, {32'h0, 32'hDEADBEEF, 32'h0BADF00D, 32'hCAFE1234}, 1'b1, 1'b0};
        tbl[5] = '{8, 1'b0, 128'h5A, 1'b0, 1'b1};
        tbl[6] = '{5, 1'b1, 128'h16, 1'b0, 1'b0};
        tbl[7] = '{70, 1'b1, 128'h25_F0E1D2C3_B4A59687, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_vld", vld, 0);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_data", data, 0);
        check("rst_bits", nbits, 0);
        check("rst_last", last, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Latched length is still zero: start request must be ignored.
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        check("len0_busy", busy, 0);

        for (int i = 0; i < 8; i++) run(tbl[i], i);

        // Reset in the middle of a 32-bit transfer.
        @(posedge clk); #1;
        len = 32; len_upd = 1'b1;
        @(posedge clk); #1;
        len_upd = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (10) begin
            edge_s = 1'b1; sdi = 1'($urandom);
            @(posedge clk); #1;
        end
        edge_s = 1'b0;
        check("mid_busy", busy, 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_vld", vld, 0);
        check("arst_stall", stall, 0);
        check("arst_data", data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(tbl[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_rx_word.md
# spi_rx_word

Parametrised SPI receive engine: deserialises `sdi` on qualified clock-edge strobes into DATA_W-bit words of configurable bit order and presents them on a valid/ready stream. A one-word output register double-buffers the shift register, so reception continues while the consumer holds the previous word. A stall output lets the SPI clock generator pause edges when both buffers are full. It sits between the SPI clock/edge generator and the Rx data FIFO or register file.

## Interface
- DATA_W, 32, word width in bits (≥ 2)
- LEN_W, 16, width of transfer bit-length
- CNT_W, $clog2(DATA_W+1), width of rx_data_bits_o (derived)

- clk_i  input  1  system clock
- rst_n_i  input  1  asynchronous active-low reset
- en_i  input  1  start request (level; sampled in IDLE only)
- sdi  input  1  serial data in
- rx_edge_i  input  1  sample strobe, one clk_i cycle per SPI sample edge
- lsb_first_i  input  1  bit order for the next transfer: 0 = MSB first, 1 = LSB first; latched at start
- rx_bits_len_i  input  LEN_W  total bits of the transfer
- rx_bits_len_update_i  input  1  load rx_bits_len_i (honoured in IDLE only)
- rx_stall_o  output  1  edges are being ignored; pause the SPI clock
- rx_busy_o  output  1  state ≠ IDLE or rx_data_vld_o
- rx_done_o  output  1  one-cycle pulse when the last word of a transfer is accepted
- rx_data_o  output  DATA_W  word, right-aligned, unused upper bits zero
- rx_data_bits_o  output  CNT_W  valid bits in rx_data_o (1..DATA_W)
- rx_last_o  output  1  word is the final word of its transfer
- rx_data_vld_o  output  1  word valid
- rx_data_rdy_i  input  1  consumer ready

## Operation
- States: IDLE, RECEIVE, STALL.
- IDLE → RECEIVE when en_i=1 and the latched length ≠ 0. Total and word-bit counters clear; the shift register clears; lsb_first_i is latched. en_i with length 0 is ignored.
- RECEIVE: each rx_edge_i samples sdi.
  - MSB first: shift left, sdi into bit 0.
  - LSB first: sdi is written to bit index = word-bit count.
- A word completes on the edge that brings the word-bit count to DATA_W, or the total count to the latched length (partial word; rx_data_bits_o = the remainder).
- On completion:
  - If the output register is empty, or is being accepted this cycle, it loads the word, bit count and last flag.
  - Otherwise the state goes to STALL.
- After the final bit is loaded to the output register, the state returns to IDLE.
- STALL: rx_stall_o=1 and rx_edge_i is ignored. On the vld&&rdy handshake the held word loads next cycle; the state goes to RECEIVE, or IDLE if that word was last.
- rx_bits_len_update_i outside IDLE is ignored.
- A new transfer may start in IDLE while the output register still holds the previous last word.

## Timing
- Reset values: all outputs 0; state IDLE; latched length 0; lsb_first 0.
- Latency: completing edge in cycle N → rx_data_vld_o=1 in cycle N+1.
- rx_data_vld_o holds, with data stable, until rx_data_rdy_i=1. It deasserts the cycle after acceptance unless a new word loads in that same cycle (back-to-back allowed).
- rx_done_o is registered: high the cycle after acceptance of a word with rx_last_o=1.
- rx_edge_i in the cycle IDLE→RECEIVE is ignored; the first sample is the first strobe while in RECEIVE.
- Length update and en_i in the same cycle: the start uses the previously latched length.
- Reset mid-transfer clears all state immediately; a pending word is lost.
- Counters never wrap: the maximum transfer is 2^LEN_W−1 bits.

## Configuration
- SPI_RX_LSB_FIRST_EN defined: lsb_first_i is honoured as above.
- SPI_RX_LSB_FIRST_EN undefined: lsb_first_i is ignored, the LSB-first write path is not built, and every transfer is MSB first.

## Test plan
- DATA_W=32, len=32, MSB first, rdy=1, sdi=0xA5A50F0F → vld one cycle after the 32nd edge; data 0xA5A50F0F, bits=32, last=1; done pulses the next cycle.
- len=40, MSB first, stream 0x12345678 then 0x9A → word 1 0x12345678/bits 32/last 0; word 2 0x0000009A/bits 8/last 1.
- LSB first (macro defined), len=8, sdi order 1,0,0,0,0,0,0,1 → data 0x00000081, bits=8. With the macro undefined, same stimulus → 0x00000081 as MSB-first shift, i.e. input order 1..1 left-shifted (verify against MSB model).
- len=96, rdy=0 → word 1 held; word 2 fills → stall_o=1 and extra edges are ignored. Raise rdy → three words delivered in order with no loss; done after the third.
- Length update during RECEIVE → ignored (transfer uses the old length); en_i with length 0 → remains IDLE, busy=0.
- Assert rst_n_i low after 10 edges of a 32-bit transfer → all outputs 0 at once; a new 32-bit transfer then completes correctly.
